// File: rtl/result_uart_tx.sv
// Captures processor Result words into a small FIFO and sends each one as
// four 8N1 UART bytes, least-significant byte first.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  result,
    input  logic                         result_valid,
    output logic                         tx,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic pop;
    logic push;

    // A full FIFO still accepts a word on the cycle the transmitter pops one.
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign push = result_valid && ((count_q < CW'(DEPTH)) || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (result_valid & ~push);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d    = mem_q[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    bit_idx_d  = 3'd0;
                    timer_d    = TIMER_RELOAD;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    timer_d   = TIMER_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_RELOAD;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                if (timer_q == '0) begin
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        shift_d    = shift_q >> 8;
                        timer_d    = TIMER_RELOAD;
                        state_d    = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
        endcase

        // Line level and busy follow the next state so both come straight from flops.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= result;
        shift_q <= shift_d;
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: logs the serial line every cycle and
// decodes frames from the log at fixed bit-centre offsets.
module tb_result_uart_tx;

    localparam int CPB    = 4;
    localparam int DEPTH  = 8;
    localparam int BYTE_T = 10 * CPB;
    localparam int WORD_T = 40 * CPB;
    localparam int LOGN   = 16384;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [31:0]                result;
    logic                       result_valid;
    logic                       tx;
    logic                       busy;
    logic                       overflow;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   peak   = 0;
    logic txlog [LOGN];

    typedef struct {
        logic [31:0]     word;
        logic [3:0][7:0] bytes;
    } vec_t;
    vec_t vecs [5];

    result_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .result_valid (result_valid),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: wait for the falling edge, log the line, track the FIFO level.
    task automatic tick();
        @(negedge clk);
        if (cyc < LOGN) txlog[cyc] = tx;
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        cyc++;
    endtask

    function automatic logic sample(input int idx);
        if (idx >= 0 && idx < LOGN) return txlog[idx];
        return 1'bx;
    endfunction

    function automatic logic [31:0] decode_word(input int base);
        logic [31:0] w;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 8; k++)
                w[j*8+k] = sample(base + j*BYTE_T + (k+1)*CPB + CPB/2);
        return w;
    endfunction

    function automatic logic frame_ok(input int base);
        logic ok = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (sample(base + j*BYTE_T + CPB/2) !== 1'b0) ok = 1'b0;
            if (sample(base + j*BYTE_T + 9*CPB + CPB/2) !== 1'b1) ok = 1'b0;
        end
        return ok;
    endfunction

    initial begin
        int          e;
        int          s;
        int          wb [20];
        logic [31:0] dec;
        logic        all_high;

        vecs[0].word = 32'hA5C30F81; vecs[0].bytes = {8'hA5, 8'hC3, 8'h0F, 8'h81};
        vecs[1].word = 32'h00000001; vecs[1].bytes = {8'h00, 8'h00, 8'h00, 8'h01};
        vecs[2].word = 32'hFFFFFFFF; vecs[2].bytes = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3].word = 32'h12345678; vecs[3].bytes = {8'h12, 8'h34, 8'h56, 8'h78};
        vecs[4].word = 32'h80000000; vecs[4].bytes = {8'h80, 8'h00, 8'h00, 8'h00};

        reset        = 1'b1;
        result_valid = 1'b0;
        result       = 32'h0;
        repeat (3) tick();
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset fifo_count", 32'(fifo_count), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        chk("idle tx", 32'(tx), 32'd1);

        // Single words from the vector table.
        for (int v = 0; v < 5; v++) begin
            result       = vecs[v].word;
            result_valid = 1'b1;
            tick();
            e            = cyc - 1;
            result_valid = 1'b0;
            chk($sformatf("v%0d count after capture", v), 32'(fifo_count), 32'd1);
            tick();
            chk($sformatf("v%0d start edge tx", v), 32'(tx), 32'd0);
            chk($sformatf("v%0d count after pop", v), 32'(fifo_count), 32'd0);
            chk($sformatf("v%0d busy in frame", v), 32'(busy), 32'd1);
            repeat (WORD_T - 1) tick();
            chk($sformatf("v%0d busy last stop", v), 32'(busy), 32'd1);
            tick();
            chk($sformatf("v%0d busy after frame", v), 32'(busy), 32'd0);
            dec = decode_word(e + 1);
            for (int j = 0; j < 4; j++)
                chk($sformatf("v%0d byte%0d", v, j), 32'(dec[j*8 +: 8]), 32'(vecs[v].bytes[j]));
            chk($sformatf("v%0d framing", v), 32'(frame_ok(e + 1)), 32'd1);
        end

        // Back-to-back strobes.
        peak         = 0;
        result       = 32'h00000001;
        result_valid = 1'b1;
        tick();
        e            = cyc - 1;
        result       = 32'hFFFFFFFF;
        tick();
        result_valid = 1'b0;
        repeat (2*WORD_T + 1) tick();
        chk("b2b busy end", 32'(busy), 32'd0);
        chk("b2b peak count", 32'(peak), 32'd1);
        chk("b2b overflow", 32'(overflow), 32'd0);
        chk("b2b last stop", 32'(sample(e + WORD_T)), 32'd1);
        chk("b2b gap idle", 32'(sample(e + WORD_T + 1)), 32'd1);
        chk("b2b second start", 32'(sample(e + WORD_T + 2)), 32'd0);
        chk("b2b word1", decode_word(e + 1), 32'h00000001);
        chk("b2b word2", decode_word(e + WORD_T + 2), 32'hFFFFFFFF);

        // Fill and overflow: ten strobes while idle.
        for (int n = 1; n <= 10; n++) begin
            result       = 32'(n);
            result_valid = 1'b1;
            tick();
            if (n == 1) e = cyc - 1;
            if (n == 9) begin
                chk("fill count at 9", 32'(fifo_count), 32'd8);
                chk("fill overflow at 9", 32'(overflow), 32'd0);
            end
        end
        result_valid = 1'b0;
        chk("fill overflow at 10", 32'(overflow), 32'd1);
        chk("fill count at 10", 32'(fifo_count), 32'd8);
        while (cyc - 1 < e + 9*(WORD_T + 1)) tick();
        chk("fill busy end", 32'(busy), 32'd0);
        chk("fill overflow sticky", 32'(overflow), 32'd1);
        for (int n = 1; n <= 9; n++)
            chk($sformatf("fill word%0d", n), decode_word(e + 1 + (WORD_T + 1)*(n - 1)), 32'(n));

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("overflow cleared by reset", 32'(overflow), 32'd0);

        // Full FIFO with a strobe exactly on the pop edge.
        for (int n = 1; n <= 9; n++) begin
            result       = 32'h100 + 32'(n);
            result_valid = 1'b1;
            tick();
            if (n == 1) e = cyc - 1;
        end
        result_valid = 1'b0;
        while (cyc - 1 < e + WORD_T + 1) tick();
        chk("fullpop count before", 32'(fifo_count), 32'd8);
        result       = 32'h0000BEEF;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        chk("fullpop count after", 32'(fifo_count), 32'd8);
        chk("fullpop overflow", 32'(overflow), 32'd0);
        chk("fullpop next start", 32'(tx), 32'd0);
        while (cyc - 1 < e + 10*(WORD_T + 1)) tick();
        chk("fullpop busy end", 32'(busy), 32'd0);
        for (int k = 1; k <= 10; k++)
            chk($sformatf("fullpop word%0d", k), decode_word(e + 1 + (WORD_T + 1)*(k - 1)),
                (k == 10) ? 32'h0000BEEF : 32'h100 + 32'(k));

        // Pointer wrap: twenty spaced words.
        for (int i = 0; i < 20; i++) begin
            result       = 32'h1000 + 32'(i);
            result_valid = 1'b1;
            tick();
            wb[i]        = cyc - 1;
            result_valid = 1'b0;
            repeat (WORD_T + 4) tick();
        end
        for (int i = 0; i < 20; i++)
            chk($sformatf("wrap word%0d", i), decode_word(wb[i] + 1), 32'h1000 + 32'(i));

        // Reset during DATA bit 3 of byte 1.
        result       = 32'h12340000;
        result_valid = 1'b1;
        tick();
        e            = cyc - 1;
        result_valid = 1'b0;
        while (cyc - 1 < e + 1 + BYTE_T + 4*CPB + 1) tick();
        chk("midreset tx before", 32'(tx), 32'd0);
        chk("midreset busy before", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset tx async", 32'(tx), 32'd1);
        chk("midreset busy async", 32'(busy), 32'd0);
        chk("midreset count async", 32'(fifo_count), 32'd0);
        result       = 32'hDEADBEEF;
        result_valid = 1'b1;
        tick();
        tick();
        result_valid = 1'b0;
        chk("strobe during reset", 32'(fifo_count), 32'd0);
        reset = 1'b0;
        s = cyc;
        repeat (20) tick();
        all_high = 1'b1;
        for (int i = s; i < s + 20; i++) if (sample(i) !== 1'b1) all_high = 1'b0;
        chk("line idle after release", 32'(all_high), 32'd1);
        chk("busy idle after release", 32'(busy), 32'd0);

        result       = 32'h0BADF00D;
        result_valid = 1'b1;
        tick();
        e            = cyc - 1;
        result_valid = 1'b0;
        repeat (WORD_T + 1) tick();
        chk("post-reset start", 32'(sample(e + 1)), 32'd0);
        chk("post-reset word", decode_word(e + 1), 32'h0BADF00D);
        chk("post-reset framing", 32'(frame_ok(e + 1)), 32'd1);
        chk("post-reset busy end", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Downstream observer for the single-cycle processor's 32-bit `Result` bus. It captures `Result` words on a strobe into a small FIFO and serializes each word off-chip as four 8N1 UART bytes, least-significant byte first. It gives board-level visibility of ALU results without stalling the core; words that arrive while the buffer is full are dropped and flagged.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit (≥2; use 4 in simulation, e.g. 868 for 100 MHz/115200).
- `DEPTH`, default 8: FIFO depth in 32-bit words; must be a power of 2, ≥2.
- `clk`  in  1  system clock; all state is rising-edge.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `result`  in  32  processor ALU result word to capture.
- `result_valid`  in  1  capture strobe; `result` is sampled on every rising edge where this is high.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  high while the FIFO is non-empty or a word is being sent.
- `overflow`  out  1  sticky: a strobe was dropped because the FIFO was full.
- `fifo_count`  out  $clog2(DEPTH+1)  number of words held, excluding the word being sent.

## Operation
- FIFO: circular buffer with `DEPTH` entries, write pointer, read pointer, and count. Pointers wrap modulo `DEPTH`.
- Push: `result_valid` pushes `result` when `fifo_count < DEPTH`, or when a pop happens in the same cycle. A simultaneous push and pop leaves the count unchanged.
- Drop: `result_valid` while full with no pop that cycle loses the word and sets `overflow`. Only `reset` clears `overflow`.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into a 32-bit shift register, set the byte index to 0, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index at 0.
  - DATA: `tx` = current byte bit[bit index], LSB first, each bit held `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. If the byte index is below 3, increment it, shift the word right by 8, and go to START. Otherwise go to IDLE.
- Byte order on the line: `result[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- The bit timer is a down-counter reloaded to `CLKS_PER_BIT-1` on every bit boundary.
- `busy` = (state != IDLE) OR (`fifo_count` != 0). It is registered-consistent, with no glitches from combinational pointer compares.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0. FSM in IDLE, pointers at 0, byte/bit indices 0.
- `tx` is a registered output.
- Latency, strobe to line: strobe sampled at edge E with FIFO empty and FSM idle.
  - `fifo_count`=1 after E.
  - Pop at edge E+1: `tx` falls and `fifo_count` returns to 0.
- Word duration: 40 × `CLKS_PER_BIT` cycles. Bytes within a word are back-to-back, with no extra idle.
- Inter-word gap: exactly 1 cycle of `tx`=1 in IDLE after the last stop bit when the next word is already queued.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronous). The FIFO is emptied, the in-flight word is discarded, and no partial byte resumes after release.
- Strobe during reset: ignored.

## Test plan
- Single word: `CLKS_PER_BIT`=4, push 0xA5C30F81 → `tx` falls 1 cycle after the capture edge. Decoded bytes 0x81, 0x0F, 0xC3, 0xA5. Frame lasts 160 cycles, then `busy`=0.
- Back-to-back strobes: push 0x00000001 and 0xFFFFFFFF on consecutive cycles → `fifo_count` peaks at 1. Second word starts exactly 1 idle cycle after the first word's last stop bit. `overflow`=0.
- Fill and overflow: `DEPTH`=8, 10 consecutive strobes with values 1..10 while idle.
  - Word 1 is popped at once, words 2..9 fill the FIFO, and word 10 is dropped.
  - `overflow`=1 and `fifo_count`=8 in the cycle after the 10th strobe.
  - Line carries 1..9 in order.
- Full with simultaneous pop: keep the FIFO at 8 and strobe exactly on the pop edge → word accepted, count stays 8, `overflow` unchanged.
- Pointer wrap: stream 20 words (0x1000+i) with spacing ≥ one word time → all 20 are received intact and in order across pointer wrap.
- Reset mid-frame: assert `reset` during the DATA bit 3 of byte 1 → `tx`=1 and `busy`=0 at once, `fifo_count`=0. A new push after release transmits cleanly from its start bit.
